// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding, data width and the bit-period helper
// that both the transmit and receive paths use.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic int calc_bit_cycles(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction

endpackage

// File: rtl/uart_tx_core_if.sv
// Byte-level valid/ready handshake into the UART transmitter.
interface uart_tx_core_if;
  logic [7:0] data_in;
  logic       valid;
  logic       ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter; o_bit_done pulses for one cycle at the end of every bit
// while i_run is high, and i_load re-phases the count to a new frame.
module uart_baud_gen #(
  parameter int BIT_CYCLES = 625
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_bit_done
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (i_run) begin
      r_cnt <= RELOAD;
    end
  end

  assign o_bit_done = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_tx_core.sv
// 8-bit LSB-first UART transmitter with valid/ready byte input and registered tx/busy.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 72_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_tx_core_if.slave   s_if,
  output logic            tx,
  output logic            busy
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ_HZ, BAUD_RATE);

  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_tx_core: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_par
    $error("uart_tx_core: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_stop_idx;
  logic       r_tx;
  logic       r_busy;
  logic       r_alive;
  logic       w_bit_done;
  logic       w_stop_last;
  logic       w_hs;
  logic       w_tx_next;
`ifdef UART_TX_PARITY_EN
  logic       r_par;
`endif

  uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_hs),
    .i_run      (r_state != IDLE),
    .o_bit_done (w_bit_done)
  );

  assign w_stop_last = (r_stop_idx == 1'(STOP_BITS - 1));
  // r_alive keeps ready low until the first edge after reset release
  assign s_if.ready  = r_alive && ((r_state == IDLE) ||
                                   (r_state == STOP && w_bit_done && w_stop_last));
  assign w_hs        = s_if.valid && s_if.ready;

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_next = r_par;
`endif
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_alive    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_alive <= 1'b1;
      r_tx    <= w_tx_next;
      r_busy  <= (r_state != IDLE);
      if (w_hs) begin
        r_state    <= START;
        r_shift    <= s_if.data_in;
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
`ifdef UART_TX_PARITY_EN
        r_par      <= (^s_if.data_in) ^ PARITY_ODD[0];
`endif
      end else if (w_bit_done) begin
        case (r_state)
          START: r_state <= DATA;
          DATA: begin
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
          PARITY: r_state <= STOP;
          STOP: begin
            if (w_stop_last) r_state <= IDLE;
            else             r_stop_idx <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances (8-bit-cycle even/odd parity, two stop bits,
// default 72 MHz/115200), table of frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_core;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] sel;
  logic       tb_valid;
  logic [7:0] tb_data;
  logic       tx_a, tx_b, tx_c, tx_d;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       tx_s, busy_s, rdy_s;

  uart_tx_core_if ifa ();
  uart_tx_core_if ifb ();
  uart_tx_core_if ifc ();
  uart_tx_core_if ifd ();

  assign ifa.valid = tb_valid && (sel == 2'd0);
  assign ifb.valid = tb_valid && (sel == 2'd1);
  assign ifc.valid = tb_valid && (sel == 2'd2);
  assign ifd.valid = tb_valid && (sel == 2'd3);
  assign ifa.data_in = tb_data;
  assign ifb.data_in = tb_data;
  assign ifc.data_in = tb_data;
  assign ifd.data_in = tb_data;

  uart_tx_core #(.CLK_FREQ_HZ(8_000_000), .BAUD_RATE(1_000_000), .STOP_BITS(1), .PARITY_ODD(0))
    dut_a (.clk(clk), .rst_n(rst_n), .s_if(ifa), .tx(tx_a), .busy(busy_a));
  uart_tx_core #(.CLK_FREQ_HZ(8_000_000), .BAUD_RATE(1_000_000), .STOP_BITS(2), .PARITY_ODD(0))
    dut_b (.clk(clk), .rst_n(rst_n), .s_if(ifb), .tx(tx_b), .busy(busy_b));
  uart_tx_core dut_c (.clk(clk), .rst_n(rst_n), .s_if(ifc), .tx(tx_c), .busy(busy_c));
  uart_tx_core #(.CLK_FREQ_HZ(8_000_000), .BAUD_RATE(1_000_000), .STOP_BITS(1), .PARITY_ODD(1))
    dut_d (.clk(clk), .rst_n(rst_n), .s_if(ifd), .tx(tx_d), .busy(busy_d));

  always_comb begin
    tx_s = tx_a; busy_s = busy_a; rdy_s = ifa.ready;
    case (sel)
      2'd1: begin tx_s = tx_b; busy_s = busy_b; rdy_s = ifb.ready; end
      2'd2: begin tx_s = tx_c; busy_s = busy_c; rdy_s = ifc.ready; end
      2'd3: begin tx_s = tx_d; busy_s = busy_d; rdy_s = ifd.ready; end
      default: ;
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Frames are {stop bit(s), [parity], d7..d0, start} so bit [0] goes out first.
  typedef struct {
    logic [1:0]  dsel;
    logic [7:0]  data;
    logic [11:0] frame_np;
    logic [11:0] frame_p;
    int          stops;
    string       name;
  } vec_t;

  vec_t tbl[7];

  task automatic run_frames(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [11:0] f0, input logic [11:0] f1,
                            input int nbits, input int nfr, input string nm);
    int bc, fl, k, bad_tx, bad_busy, bad_rdy;
    logic [11:0] fr;
    logic [7:0]  d, rx;
    logic        e_rdy;
    bc = (sel == 2'd2) ? 625 : 8;
    fl = nbits * bc;
    chk($sformatf("%s.ready_idle", nm), rdy_s, 1);
    tb_data  = d0;
    tb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (nfr == 2) tb_data = d1;
    else          tb_valid = 1'b0;
    chk($sformatf("%s.tx_lat", nm), tx_s, 1);
    chk($sformatf("%s.busy_lat", nm), busy_s, 0);
    for (int f = 0; f < nfr; f++) begin
      fr = (f == 0) ? f0 : f1;
      d  = (f == 0) ? d0 : d1;
      rx = '0;
      bad_busy = 0;
      bad_rdy  = 0;
      for (int b = 0; b < nbits; b++) begin
        bad_tx = 0;
        for (int c = 0; c < bc; c++) begin
          @(negedge clk);
          k = f * fl + b * bc + c;
          e_rdy = (k == fl - 2) || (k >= nfr * fl - 2);
          if (tx_s !== fr[b])   bad_tx++;
          if (busy_s !== 1'b1)  bad_busy++;
          if (rdy_s !== e_rdy)  bad_rdy++;
          if (c == bc / 2 && b >= 1 && b <= 8) rx[b-1] = tx_s;
          if (nfr == 2 && k == fl - 1) tb_valid = 1'b0;
        end
        chk($sformatf("%s.f%0d.bit%0d_cycles_wrong", nm, f, b), bad_tx, 0);
      end
      chk($sformatf("%s.f%0d.rx_byte", nm, f), rx, d);
      chk($sformatf("%s.f%0d.busy_drops", nm, f), bad_busy, 0);
      chk($sformatf("%s.f%0d.ready_pattern_errs", nm, f), bad_rdy, 0);
    end
    @(negedge clk);
    chk($sformatf("%s.tx_idle", nm), tx_s, 1);
    chk($sformatf("%s.busy_end", nm), busy_s, 0);
    chk($sformatf("%s.ready_end", nm), rdy_s, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    rst_n    = 1'b0;
    tb_valid = 1'b0;
    tb_data  = 8'h00;
    sel      = 2'd0;

    tbl[0] = '{2'd0, 8'hA5, 12'b00_1_10100101_0, 12'b0_1_0_10100101_0, 1, "a5"};
    tbl[1] = '{2'd0, 8'h01, 12'b00_1_00000001_0, 12'b0_1_1_00000001_0, 1, "01"};
    tbl[2] = '{2'd0, 8'h80, 12'b00_1_10000000_0, 12'b0_1_1_10000000_0, 1, "80"};
    tbl[3] = '{2'd1, 8'h55, 12'b0_11_01010101_0, 12'b11_0_01010101_0, 2, "stop2_55"};
    tbl[4] = '{2'd3, 8'h07, 12'b00_1_00000111_0, 12'b0_1_0_00000111_0, 1, "odd_07"};
    tbl[5] = '{2'd0, 8'h07, 12'b00_1_00000111_0, 12'b0_1_1_00000111_0, 1, "even_07"};
    tbl[6] = '{2'd2, 8'h41, 12'b00_1_01000001_0, 12'b0_1_0_01000001_0, 1, "dflt_41"};

    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk($sformatf("rst.tx%0d", s), tx_s, 1);
      chk($sformatf("rst.busy%0d", s), busy_s, 0);
      chk($sformatf("rst.ready%0d", s), rdy_s, 0);
    end
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.ready_before_edge", rdy_s, 0);
    @(negedge clk);
    chk("rel.ready_after_edge", rdy_s, 1);

    for (int i = 0; i < 7; i++) begin
      sel = tbl[i].dsel;
      #1;
      nb = 9 + (PAR_EN ? 1 : 0) + tbl[i].stops;
      run_frames(tbl[i].data, 8'h00, PAR_EN ? tbl[i].frame_p : tbl[i].frame_np, 12'h000,
                 nb, 1, tbl[i].name);
      @(negedge clk);
    end

    // Back-to-back: valid held, second start bit must follow the last stop cycle directly.
    sel = 2'd0;
    #1;
    run_frames(8'h00, 8'hFF,
               PAR_EN ? 12'b0_1_0_00000000_0 : 12'b00_1_00000000_0,
               PAR_EN ? 12'b0_1_0_11111111_0 : 12'b00_1_11111111_0,
               PAR_EN ? 11 : 10, 2, "b2b");
    @(negedge clk);

    // Mid-frame reset: tx/busy must react without waiting for a clock edge.
    tb_data  = 8'h00;
    tb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tb_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("midrst.tx_before", tx_a, 0);
    chk("midrst.busy_before", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.tx_async", tx_a, 1);
    chk("midrst.busy_async", busy_a, 0);
    chk("midrst.ready_async", ifa.ready, 0);
    repeat (3) @(negedge clk);
    chk("midrst.tx_held", tx_a, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst.ready_back", ifa.ready, 1);
    run_frames(8'h3C, 8'h00, PAR_EN ? 12'b0_1_0_00111100_0 : 12'b00_1_00111100_0, 12'h000,
               PAR_EN ? 11 : 10, 1, "post_rst_3c");

    repeat (5) @(negedge clk);
    sel = 2'd0;
    #1;
    chk("idle.tx_stays_high", tx_a, 1);
    chk("idle.busy_low", busy_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
